mips_ctrl_fsm: RTL and testbench
================================

# mips_ctrl_fsm

- Multi-cycle main controller for the 16-bit MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Issues ALU operation codes and operand selects to the ALU, and consumes the ALU's `zero_flag` for branches.
- Handshakes with the unified instruction/data memory through `mem_req`/`mem_ready`; drives every datapath enable.

## Interface
Parameters: none.

Ports:
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; state returns to FETCH on the next edge
- opcode  in  3  IR[15:13]
- funct  in  3  IR[2:0], R-type only
- zero_flag  in  1  ALU zero output, same cycle
- mem_ready  in  1  memory completes the current access this cycle
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt
- alu_src_a  out  1  0=PC, 1=register A
- alu_src_b  out  2  00=register B, 01=constant 2, 10=sign-extended imm, 11=imm<<1
- iord  out  1  memory address: 0=PC, 1=ALUOut
- mem_req  out  1  memory access request
- mem_we  out  1  write qualifier for `mem_req`
- ir_write  out  1  load IR
- pc_en  out  1  load PC
- pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target
- reg_write  out  1  register file write
- reg_dst  out  2  write register: 00=rt, 01=rd, 10=r7
- mem_to_reg  out  2  writeback data: 00=ALUOut, 01=MDR, 10=PC
- illegal_op  out  1  one-cycle pulse on an undefined encoding

## Operation
Output rules:
- All outputs are combinational from state, plus `opcode`/`funct`/`mem_ready`/`zero_flag` where stated.
- Every output not listed for a state is 0.
- After reset the state is FETCH, so outputs take FETCH values.

Opcodes:
- 000 R-type; valid funct 000 to 100
- 001 slti
- 010 lw
- 011 sw
- 100 beq
- 101 j
- 110 addi
- 111 jal (macro-gated)

States and outputs:
- FETCH
  - Outputs: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_control=000, pc_source=00; ir_write=pc_en=mem_ready.
  - Stay while !mem_ready; go to DECODE when mem_ready.
- DECODE
  - Outputs: alu_src_a=0, alu_src_b=11, alu_control=000 (branch target into ALUOut).
  - Next state by opcode: lw/sw -> MEM_ADDR; R -> EXEC_R; slti/addi -> EXEC_I; beq -> BRANCH; j -> JUMP; jal -> JAL.
  - Undefined opcode -> FETCH with illegal_op=1.
- MEM_ADDR
  - Outputs: alu_src_a=1, alu_src_b=10, alu_control=000.
  - Next: lw -> MEM_READ, sw -> MEM_WRITE.
- MEM_READ
  - Outputs: mem_req=1, iord=1.
  - Wait for mem_ready, then go to MEM_WB.
- MEM_WB
  - Outputs: reg_write=1, reg_dst=00, mem_to_reg=01.
  - Next: FETCH.
- MEM_WRITE
  - Outputs: mem_req=1, mem_we=1, iord=1.
  - Wait for mem_ready, then go to FETCH.
- EXEC_R
  - Outputs: alu_src_a=1, alu_src_b=00, alu_control=funct.
  - funct 101 to 111: illegal_op=1, go to FETCH, no write.
  - Otherwise go to R_WB.
- R_WB
  - Outputs: reg_write=1, reg_dst=01, mem_to_reg=00.
  - Next: FETCH.
- EXEC_I
  - Outputs: alu_src_a=1, alu_src_b=10, alu_control=100 for slti, 000 for addi.
  - Next: I_WB.
- I_WB
  - Outputs: reg_write=1, reg_dst=00, mem_to_reg=00.
  - Next: FETCH.
- BRANCH
  - Outputs: alu_src_a=1, alu_src_b=00, alu_control=001, pc_source=01, pc_en=zero_flag.
  - Next: FETCH.
- JUMP
  - Outputs: pc_source=10, pc_en=1.
  - Next: FETCH.
- JAL
  - Outputs: pc_source=10, pc_en=1, reg_write=1, reg_dst=10, mem_to_reg=10.
  - Next: FETCH.

## Timing
Cycles per instruction, with zero memory wait:

| Instruction | Cycles |
|---|---|
| beq, j, jal | 3 |
| R-type, slti, addi, sw | 4 |
| lw | 5 |

Boundary rules:
- Each cycle `mem_ready` is held low adds one cycle in FETCH, MEM_READ or MEM_WRITE.
- `mem_ready` outside a requesting state is ignored.
- `reset` wins over every transition, including mid-wait. An access pending in MEM_WRITE is abandoned: `mem_req`/`mem_we` drop on the reset edge.
- `illegal_op` is high for exactly one cycle, in the state that detects the fault.
- `pc_en` and `reg_write` are never both high except in JAL.
- `mem_we` is never high without `mem_req`.

## Configuration
Macro `MIPS_CTRL_JAL_EN`:
- Defined: opcode 111 decodes to the JAL state. The return address (PC, already incremented by 2) is written to r7 while PC loads the jump target.
- Undefined: the JAL state is absent and opcode 111 is illegal (DECODE -> FETCH, illegal_op=1).

## Structure
- Package `mips_pkg` holds:
  - opcode and funct constants
  - ALU op codes (000 to 100)
  - `alu_src_b`, `pc_source`, `reg_dst` and `mem_to_reg` encodings
  - the state enum
- The existing ALU imports the ALU op codes from `mips_pkg`.
- One sub-module, `mips_alu_dec`: combinational; maps (state class, opcode, funct) to alu_control plus a funct-valid flag.

## Test plan
- Reset asserted mid-MEM_WRITE with mem_ready=0 -> next cycle state is FETCH, mem_we=0, mem_req=1, iord=0.
- add (opcode 000, funct 000), mem_ready always 1 -> ir_write at cycle 0; alu_control=000 with alu_src_b=00 at cycle 2; reg_write with reg_dst=01 at cycle 3; next FETCH at cycle 4.
- lw with mem_ready low for 2 cycles in MEM_READ -> mem_req/iord held for 3 cycles; reg_write with mem_to_reg=01 one cycle after mem_ready; 7 cycles total.
- beq with zero_flag=1, then again with zero_flag=0 -> pc_en=1 with pc_source=01 in BRANCH; then pc_en=0 in BRANCH.
- R-type funct 110, and opcode 111 without the macro -> illegal_op pulses exactly one cycle, no reg_write, returns to FETCH.
- With `MIPS_CTRL_JAL_EN`, opcode 111 -> in cycle 2: pc_en=1, pc_source=10, reg_write=1, reg_dst=10, mem_to_reg=10.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings and state enum for the 16-bit MIPS multi-cycle controller
package mips_pkg;

  // Opcodes (IR[15:13])
  localparam logic [2:0] OP_RTYPE = 3'b000;
  localparam logic [2:0] OP_SLTI  = 3'b001;
  localparam logic [2:0] OP_LW    = 3'b010;
  localparam logic [2:0] OP_SW    = 3'b011;
  localparam logic [2:0] OP_BEQ   = 3'b100;
  localparam logic [2:0] OP_J     = 3'b101;
  localparam logic [2:0] OP_ADDI  = 3'b110;
  localparam logic [2:0] OP_JAL   = 3'b111;

  // R-type funct codes (IR[2:0]); they coincide with the ALU op codes
  localparam logic [2:0] FUNCT_ADD = 3'b000;
  localparam logic [2:0] FUNCT_SUB = 3'b001;
  localparam logic [2:0] FUNCT_AND = 3'b010;
  localparam logic [2:0] FUNCT_OR  = 3'b011;
  localparam logic [2:0] FUNCT_SLT = 3'b100;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  // ALU operand B select
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_TWO    = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Destination register select
  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_R7 = 2'b10;

  // Writeback data select
  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  // How the ALU decoder should interpret the current state
  typedef enum logic [1:0] {
    ACLS_ADD,
    ACLS_RTYPE,
    ACLS_ITYPE,
    ACLS_SUB
  } alu_cls_e;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_EXEC_R,
    S_R_WB,
    S_EXEC_I,
    S_I_WB,
    S_BRANCH,
    S_JUMP
`ifdef MIPS_CTRL_JAL_EN
    , S_JAL
`endif
  } state_e;

  // Only funct 000..100 name an ALU operation
  function automatic logic funct_is_valid(input logic [2:0] f);
    return f <= FUNCT_SLT;
  endfunction

endpackage

// File: rtl/mips_alu_dec.sv
// rtl/mips_alu_dec.sv - maps (state class, opcode, funct) to the ALU op code and funct-valid flag
module mips_alu_dec
  import mips_pkg::*;
(
  input  alu_cls_e   alu_cls_i,
  input  logic [2:0] opcode_i,
  input  logic [2:0] funct_i,
  output logic [2:0] alu_control_o,
  output logic       funct_valid_o
);

  // Pick the ALU op; R-type passes funct straight through, even when it is undefined
  always_comb begin
    alu_control_o = ALU_ADD;
    funct_valid_o = funct_is_valid(funct_i);
    case (alu_cls_i)
      ACLS_RTYPE: alu_control_o = funct_i;
      ACLS_ITYPE: alu_control_o = (opcode_i == OP_SLTI) ? ALU_SLT : ALU_ADD;
      ACLS_SUB:   alu_control_o = ALU_SUB;
      default:    alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_ctrl_fsm.sv
// rtl/mips_ctrl_fsm.sv - multi-cycle main controller; MIPS_CTRL_JAL_EN enables the jal instruction
module mips_ctrl_fsm
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic [2:0] funct,
  input  logic       zero_flag,
  input  logic       mem_ready,
  output logic [2:0] alu_control,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       iord,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] pc_source,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       illegal_op
);

  state_e   state_q, state_d;
  alu_cls_e alu_cls;
  logic     funct_valid;

  mips_alu_dec u_alu_dec (
    .alu_cls_i     (alu_cls),
    .opcode_i      (opcode),
    .funct_i       (funct),
    .alu_control_o (alu_control),
    .funct_valid_o (funct_valid)
  );

  // State register; reset abandons any pending access
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state and datapath controls; everything not driven by a state stays 0
  always_comb begin
    state_d    = state_q;
    alu_cls    = ACLS_ADD;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    iord       = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_write   = 1'b0;
    pc_en      = 1'b0;
    pc_source  = PCSRC_ALU;
    reg_write  = 1'b0;
    reg_dst    = REGDST_RT;
    mem_to_reg = WB_ALUOUT;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_TWO;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Branch target computed speculatively into ALUOut
        alu_src_b = SRCB_IMM_SH;
        case (opcode)
          OP_LW, OP_SW:    state_d = S_MEM_ADDR;
          OP_RTYPE:        state_d = S_EXEC_R;
          OP_SLTI, OP_ADDI: state_d = S_EXEC_I;
          OP_BEQ:          state_d = S_BRANCH;
          OP_J:            state_d = S_JUMP;
`ifdef MIPS_CTRL_JAL_EN
          OP_JAL:          state_d = S_JAL;
`endif
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        reg_dst    = REGDST_RT;
        mem_to_reg = WB_MDR;
        state_d    = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REG;
        alu_cls   = ACLS_RTYPE;
        if (!funct_valid) begin
          illegal_op = 1'b1;
          state_d    = S_FETCH;
        end else begin
          state_d = S_R_WB;
        end
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = REGDST_RD;
        state_d   = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_cls   = ACLS_ITYPE;
        state_d   = S_I_WB;
      end
      S_I_WB: begin
        reg_write = 1'b1;
        reg_dst   = REGDST_RT;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REG;
        alu_cls   = ACLS_SUB;
        pc_source = PCSRC_ALUOUT;
        pc_en     = zero_flag;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_source = PCSRC_JUMP;
        pc_en     = 1'b1;
        state_d   = S_FETCH;
      end
`ifdef MIPS_CTRL_JAL_EN
      S_JAL: begin
        // Return address (PC already advanced by 2) goes to r7
        pc_source  = PCSRC_JUMP;
        pc_en      = 1'b1;
        reg_write  = 1'b1;
        reg_dst    = REGDST_R7;
        mem_to_reg = WB_PC;
        state_d    = S_FETCH;
      end
`endif
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// tb/tb_mips_ctrl_fsm.sv - self-checking bench for mips_ctrl_fsm against an instruction-level step model
module tb_mips_ctrl_fsm;

  typedef struct packed {
    logic [2:0] alu_control;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       iord;
    logic       mem_req;
    logic       mem_we;
    logic       ir_write;
    logic       pc_en;
    logic [1:0] pc_source;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       illegal_op;
  } outs_t;

  typedef struct {
    outs_t o;
    bit    wait_mem;
    bit    fetch_gate;
    bit    zero_gate;
  } step_t;

`ifdef MIPS_CTRL_JAL_EN
  localparam bit JAL_EN = 1'b1;
`else
  localparam bit JAL_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] opcode, funct;
  logic       zero_flag, mem_ready;
  logic [2:0] alu_control;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       iord, mem_req, mem_we, ir_write, pc_en;
  logic [1:0] pc_source;
  logic       reg_write;
  logic [1:0] reg_dst, mem_to_reg;
  logic       illegal_op;
  outs_t      dut_o;

  int checks = 0;
  int errors = 0;
  step_t steps[$];
  outs_t obs[$];

  always #5 clk = ~clk;

  mips_ctrl_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .zero_flag(zero_flag), .mem_ready(mem_ready),
    .alu_control(alu_control), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .iord(iord), .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write),
    .pc_en(pc_en), .pc_source(pc_source), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .illegal_op(illegal_op)
  );

  assign dut_o = {alu_control, alu_src_a, alu_src_b, iord, mem_req, mem_we, ir_write,
                  pc_en, pc_source, reg_write, reg_dst, mem_to_reg, illegal_op};

  // Expected outputs while fetching, for a given mem_ready
  function automatic outs_t fetch_exp(input bit rdy);
    outs_t o = '0;
    o.mem_req = 1'b1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_en = rdy;
    return o;
  endfunction

  function automatic void add_step(input outs_t o, input bit w, input bit fg, input bit zg);
    step_t s;
    s.o = o; s.wait_mem = w; s.fetch_gate = fg; s.zero_gate = zg;
    steps.push_back(s);
  endfunction

  // Cycle-by-cycle behaviour of one instruction, derived from its semantics
  function automatic void build_steps(input logic [2:0] op, input logic [2:0] fn);
    outs_t o;
    steps.delete();
    o = fetch_exp(1'b0); add_step(o, 1, 1, 0);
    o = '0; o.alu_src_b = 2'b11;
    if (op == 3'b111 && !JAL_EN) begin
      o.illegal_op = 1'b1; add_step(o, 0, 0, 0); return;
    end
    add_step(o, 0, 0, 0);
    case (op)
      3'b010, 3'b011: begin
        o = '0; o.alu_src_a = 1; o.alu_src_b = 2'b10; add_step(o, 0, 0, 0);
        o = '0; o.mem_req = 1; o.iord = 1; o.mem_we = (op == 3'b011);
        add_step(o, 1, 0, 0);
        if (op == 3'b010) begin
          o = '0; o.reg_write = 1; o.mem_to_reg = 2'b01; add_step(o, 0, 0, 0);
        end
      end
      3'b000: begin
        o = '0; o.alu_src_a = 1; o.alu_control = fn; o.illegal_op = (fn > 3'd4);
        add_step(o, 0, 0, 0);
        if (fn <= 3'd4) begin
          o = '0; o.reg_write = 1; o.reg_dst = 2'b01; add_step(o, 0, 0, 0);
        end
      end
      3'b001, 3'b110: begin
        o = '0; o.alu_src_a = 1; o.alu_src_b = 2'b10;
        o.alu_control = (op == 3'b001) ? 3'b100 : 3'b000; add_step(o, 0, 0, 0);
        o = '0; o.reg_write = 1; add_step(o, 0, 0, 0);
      end
      3'b100: begin
        o = '0; o.alu_src_a = 1; o.alu_control = 3'b001; o.pc_source = 2'b01;
        add_step(o, 0, 0, 1);
      end
      3'b101: begin
        o = '0; o.pc_source = 2'b10; o.pc_en = 1; add_step(o, 0, 0, 0);
      end
      default: begin
        o = '0; o.pc_source = 2'b10; o.pc_en = 1; o.reg_write = 1;
        o.reg_dst = 2'b10; o.mem_to_reg = 2'b10; add_step(o, 0, 0, 0);
      end
    endcase
  endfunction

  // Run one instruction from FETCH, comparing every cycle with the model.
  // rdy_low bit k forces mem_ready low in cycle k; zf_mode 0/1 fixed, 2 random.
  task automatic run_instr(input logic [2:0] op, input logic [2:0] fn,
                           input logic [31:0] rdy_low, input bit rand_rdy,
                           input int zf_mode, output int cycles);
    int idx = 0;
    int cyc = 0;
    bit rdy, zf;
    outs_t exp_o;
    build_steps(op, fn);
    obs.delete();
    opcode = op; funct = fn;
    while (idx < steps.size() && cyc < 64) begin
      rdy = rand_rdy ? ($urandom_range(0, 3) != 0) : !(cyc < 32 && rdy_low[cyc]);
      zf  = (zf_mode == 2) ? 1'($urandom_range(0, 1)) : (zf_mode == 1);
      mem_ready = rdy; zero_flag = zf;
      #3;
      exp_o = steps[idx].o;
      if (steps[idx].fetch_gate) begin exp_o.ir_write = rdy; exp_o.pc_en = rdy; end
      if (steps[idx].zero_gate) exp_o.pc_en = zf;
      obs.push_back(dut_o);
      checks++;
      if (dut_o !== exp_o) begin
        errors++;
        $display("FAIL instr_cycle op=%b fn=%b cyc=%0d rdy=%0d zf=%0d got=%h exp=%h",
                 op, fn, cyc, rdy, zf, dut_o, exp_o);
      end
      if (!steps[idx].wait_mem || rdy) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 64) begin
      errors++;
      $display("FAIL instr_timeout op=%b fn=%b cycles=%0d limit=64", op, fn, cyc);
    end
    cycles = cyc;
  endtask

  task automatic test_reset();
    reset = 1; opcode = 0; funct = 0; zero_flag = 0; mem_ready = 1;
    repeat (3) @(posedge clk);
    #1; reset = 0; mem_ready = 0;
    #3;
    checks++;
    if (dut_o !== fetch_exp(1'b0)) begin
      errors++; $display("FAIL reset_state got=%h exp=%h", dut_o, fetch_exp(1'b0));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    int cyc;
    run_instr(3'b000, 3'b000, 32'h0, 0, 0, cyc);
    if (obs.size() >= 4) begin
      checks++;
      if (obs[0].ir_write !== 1'b1) begin
        errors++; $display("FAIL add_ir_write got=%b exp=1", obs[0].ir_write);
      end
      checks++;
      if (obs[2].alu_control !== 3'b000 || obs[2].alu_src_b !== 2'b00) begin
        errors++; $display("FAIL add_exec got=%b/%b exp=000/00", obs[2].alu_control, obs[2].alu_src_b);
      end
      checks++;
      if (obs[3].reg_write !== 1'b1 || obs[3].reg_dst !== 2'b01) begin
        errors++; $display("FAIL add_wb got=%b/%b exp=1/01", obs[3].reg_write, obs[3].reg_dst);
      end
    end
    mem_ready = 0; #3;
    checks++;
    if (dut_o !== fetch_exp(1'b0)) begin
      errors++; $display("FAIL add_next_fetch got=%h exp=%h", dut_o, fetch_exp(1'b0));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_lw_wait();
    int cyc;
    run_instr(3'b010, 3'b000, 32'h18, 0, 0, cyc);
    if (obs.size() >= 7) begin
      for (int k = 3; k <= 5; k++) begin
        checks++;
        if (obs[k].mem_req !== 1'b1 || obs[k].iord !== 1'b1) begin
          errors++; $display("FAIL lw_read_hold cyc=%0d got=%b/%b exp=1/1", k, obs[k].mem_req, obs[k].iord);
        end
      end
      checks++;
      if (obs[6].reg_write !== 1'b1 || obs[6].mem_to_reg !== 2'b01) begin
        errors++; $display("FAIL lw_wb got=%b/%b exp=1/01", obs[6].reg_write, obs[6].mem_to_reg);
      end
    end
    mem_ready = 0; #3;
    checks++;
    if (dut_o !== fetch_exp(1'b0)) begin
      errors++; $display("FAIL lw_next_fetch got=%h exp=%h", dut_o, fetch_exp(1'b0));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_beq();
    int cyc;
    run_instr(3'b100, 3'b000, 32'h0, 0, 1, cyc);
    if (obs.size() >= 3) begin
      checks++;
      if (obs[2].pc_en !== 1'b1 || obs[2].pc_source !== 2'b01) begin
        errors++; $display("FAIL beq_taken got=%b/%b exp=1/01", obs[2].pc_en, obs[2].pc_source);
      end
    end
    run_instr(3'b100, 3'b000, 32'h0, 0, 0, cyc);
    if (obs.size() >= 3) begin
      checks++;
      if (obs[2].pc_en !== 1'b0) begin
        errors++; $display("FAIL beq_not_taken got=%b exp=0", obs[2].pc_en);
      end
    end
  endtask

  task automatic test_illegal();
    int cyc;
    int pulses;
    run_instr(3'b000, 3'b110, 32'h0, 0, 0, cyc);
    pulses = 0;
    foreach (obs[k]) pulses += int'(obs[k].illegal_op);
    checks++;
    if (pulses !== 1) begin
      errors++; $display("FAIL illegal_funct_pulses got=%0d exp=1", pulses);
    end
    foreach (obs[k]) begin
      checks++;
      if (obs[k].reg_write !== 1'b0) begin
        errors++; $display("FAIL illegal_funct_regwrite cyc=%0d got=%b exp=0", k, obs[k].reg_write);
      end
    end
    run_instr(3'b111, 3'b000, 32'h0, 0, 0, cyc);
`ifdef MIPS_CTRL_JAL_EN
    if (obs.size() >= 3) begin
      checks++;
      if (obs[2].pc_en !== 1 || obs[2].pc_source !== 2'b10 || obs[2].reg_write !== 1 ||
          obs[2].reg_dst !== 2'b10 || obs[2].mem_to_reg !== 2'b10) begin
        errors++; $display("FAIL jal_cycle2 got=%h", obs[2]);
      end
    end
`else
    pulses = 0;
    foreach (obs[k]) pulses += int'(obs[k].illegal_op);
    checks++;
    if (pulses !== 1) begin
      errors++; $display("FAIL illegal_op111_pulses got=%0d exp=1", pulses);
    end
`endif
    mem_ready = 0; #3;
    checks++;
    if (dut_o !== fetch_exp(1'b0)) begin
      errors++; $display("FAIL illegal_next_fetch got=%h exp=%h", dut_o, fetch_exp(1'b0));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_write();
    opcode = 3'b011; funct = 3'b000; mem_ready = 1;
    repeat (3) begin @(posedge clk); #1; end
    mem_ready = 0; reset = 1; #3;
    checks++;
    if (dut_o.mem_we !== 1'b1 || dut_o.mem_req !== 1'b1) begin
      errors++; $display("FAIL rst_write_pending got=%b/%b exp=1/1", dut_o.mem_we, dut_o.mem_req);
    end
    @(posedge clk); #1;
    reset = 0; #3;
    checks++;
    if (dut_o !== fetch_exp(1'b0)) begin
      errors++; $display("FAIL rst_mid_write got=%h exp=%h", dut_o, fetch_exp(1'b0));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int cyc;
    for (int n = 0; n < 150; n++)
      run_instr(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 32'h0, 1, 2, cyc);
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_wait();
    test_beq();
    test_illegal();
    test_reset_mid_write();
    test_random();
    test_add();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
